mem_wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback data formation for the 5-stage MIPS pipeline.
- Captures the MEM-stage result and performs load byte/halfword extraction and sign/zero extension.
- Selects ALU result, load data or link address as the writeback value.
- Drives the register-file write port and the WB-to-ID forwarding unit: RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb.

---
 rtl/mem_wb_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_wb_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction and writeback select.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   Stall_wb/Flush_wb   hold / bubble control (flush wins)
//   *_mem               MEM-stage instruction bundle
//   Valid_wb            WB holds a real instruction
//   RegWrite*_wb        register-file write port / WB forwarding source
//   AdEL_wb/FaultPC_wb  misaligned-load fault and faulting PC
//   Retired_cnt         instructions retired without fault
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Stall_wb,
    input  logic              Flush_wb,
    input  logic              Valid_mem,
    input  logic              RegWrite_mem,
    input  logic [4:0]        RegWriteAddr_mem,
    input  logic              MemToReg_mem,
    input  logic              Link_mem,
    input  logic [2:0]        LoadType_mem,
    input  logic [DATA_W-1:0] ALUResult_mem,
    input  logic [DATA_W-1:0] PC_plus4_mem,
    input  logic [DATA_W-1:0] MemData_mem,
    output logic              Valid_wb,
    output logic              RegWrite_wb,
    output logic [4:0]        RegWriteAddr_wb,
    output logic [DATA_W-1:0] RegWriteData_wb,
    output logic              AdEL_wb,
    output logic [DATA_W-1:0] FaultPC_wb,
    output logic [CNT_W-1:0]  Retired_cnt
);

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic              r_valid;
    logic              r_regwrite;
    logic [4:0]        r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_adel;
    logic [DATA_W-1:0] r_fault_pc;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_is_byte;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_misalign;
    logic              w_regwrite;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_wdata;
    logic              w_retire;
    logic              w_capture;

    // Unlisted load codes behave as LW.
    assign w_is_byte = (LoadType_mem == LT_LB) || (LoadType_mem == LT_LBU);
    assign w_is_half = (LoadType_mem == LT_LH) || (LoadType_mem == LT_LHU);
    assign w_is_word = ~w_is_byte & ~w_is_half;

    always_comb begin
        w_misalign = 1'b0;
        if (Valid_mem && MemToReg_mem) begin
            w_misalign = (w_is_half & ALUResult_mem[0])
                       | (w_is_word & (|ALUResult_mem[1:0]));
        end
    end

    // $0 is never written so forwarding can never match it.
    assign w_regwrite = Valid_mem & RegWrite_mem
                      & (|RegWriteAddr_mem) & ~w_misalign;

    always_comb begin
        w_byte = MemData_mem[7:0];
        unique case (ALUResult_mem[1:0])
            2'd0: w_byte = MemData_mem[7:0];
            2'd1: w_byte = MemData_mem[15:8];
            2'd2: w_byte = MemData_mem[23:16];
            2'd3: w_byte = MemData_mem[31:24];
        endcase
    end

    assign w_half = ALUResult_mem[1] ? MemData_mem[31:16]
                                     : MemData_mem[15:0];

    always_comb begin
        w_load = MemData_mem;
        unique case (LoadType_mem)
            LT_LB:   w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LT_LBU:  w_load = {{(DATA_W-8){1'b0}}, w_byte};
            LT_LH:   w_load = {{(DATA_W-16){w_half[15]}}, w_half};
            LT_LHU:  w_load = {{(DATA_W-16){1'b0}}, w_half};
            default: w_load = MemData_mem;
        endcase
    end

    // Link beats load if both are (illegally) raised.
    always_comb begin
        w_wdata = '0;
        if (w_regwrite) begin
            if (Link_mem) begin
                w_wdata = PC_plus4_mem + DATA_W'(4);
            end else if (MemToReg_mem) begin
                w_wdata = w_load;
            end else begin
                w_wdata = ALUResult_mem;
            end
        end
    end

    assign w_capture = ~Flush_wb & ~Stall_wb;
    assign w_retire  = Valid_mem & ~w_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_adel     <= 1'b0;
            r_fault_pc <= '0;
        end else if (Flush_wb) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_adel     <= 1'b0;
            r_fault_pc <= '0;
        end else if (!Stall_wb) begin
            r_valid    <= Valid_mem;
            r_regwrite <= w_regwrite;
            r_addr     <= w_regwrite ? RegWriteAddr_mem : 5'd0;
            r_data     <= w_wdata;
            r_adel     <= w_misalign;
            r_fault_pc <= w_misalign ? (PC_plus4_mem - DATA_W'(4))
                                     : '0;
        end
    end

    // Counter ignores flushes and stalls; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_capture && w_retire) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign Valid_wb        = r_valid;
    assign RegWrite_wb     = r_regwrite;
    assign RegWriteAddr_wb = r_addr;
    assign RegWriteData_wb = r_data;
    assign AdEL_wb         = r_adel;
    assign FaultPC_wb      = r_fault_pc;
    assign Retired_cnt     = r_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed literals plus
// randomized traffic against a behavioural model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Stall_wb = 1'b0;
    logic        Flush_wb = 1'b0;
    logic        Valid_mem = 1'b0;
    logic        RegWrite_mem = 1'b0;
    logic [4:0]  RegWriteAddr_mem = '0;
    logic        MemToReg_mem = 1'b0;
    logic        Link_mem = 1'b0;
    logic [2:0]  LoadType_mem = '0;
    logic [31:0] ALUResult_mem = '0;
    logic [31:0] PC_plus4_mem = '0;
    logic [31:0] MemData_mem = '0;

    logic        Valid_wb, RegWrite_wb, AdEL_wb;
    logic [4:0]  RegWriteAddr_wb;
    logic [31:0] RegWriteData_wb, FaultPC_wb, Retired_cnt;

    logic        v4, rw4, ad4;
    logic [4:0]  a4;
    logic [31:0] d4, f4;
    logic [3:0]  c4;

    int total = 0;
    int bad = 0;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n),
        .Stall_wb(Stall_wb), .Flush_wb(Flush_wb),
        .Valid_mem(Valid_mem), .RegWrite_mem(RegWrite_mem),
        .RegWriteAddr_mem(RegWriteAddr_mem),
        .MemToReg_mem(MemToReg_mem), .Link_mem(Link_mem),
        .LoadType_mem(LoadType_mem), .ALUResult_mem(ALUResult_mem),
        .PC_plus4_mem(PC_plus4_mem), .MemData_mem(MemData_mem),
        .Valid_wb(Valid_wb), .RegWrite_wb(RegWrite_wb),
        .RegWriteAddr_wb(RegWriteAddr_wb),
        .RegWriteData_wb(RegWriteData_wb), .AdEL_wb(AdEL_wb),
        .FaultPC_wb(FaultPC_wb), .Retired_cnt(Retired_cnt)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .Stall_wb(Stall_wb), .Flush_wb(Flush_wb),
        .Valid_mem(Valid_mem), .RegWrite_mem(RegWrite_mem),
        .RegWriteAddr_mem(RegWriteAddr_mem),
        .MemToReg_mem(MemToReg_mem), .Link_mem(Link_mem),
        .LoadType_mem(LoadType_mem), .ALUResult_mem(ALUResult_mem),
        .PC_plus4_mem(PC_plus4_mem), .MemData_mem(MemData_mem),
        .Valid_wb(v4), .RegWrite_wb(rw4),
        .RegWriteAddr_wb(a4), .RegWriteData_wb(d4),
        .AdEL_wb(ad4), .FaultPC_wb(f4), .Retired_cnt(c4)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        m_valid, m_rw, m_adel;
    logic [4:0]  m_addr;
    logic [31:0] m_data, m_fpc;
    int unsigned m_cnt;

    function automatic logic [31:0] load_val(
        input logic [2:0] lt, input logic [31:0] ea,
        input logic [31:0] md);
        int unsigned b, h;
        b = (md >> (8 * (ea % 4))) % 256;
        h = (md >> (16 * ((ea / 2) % 2))) % 65536;
        case (lt)
            3'd1: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd2: return 32'(b);
            3'd3: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd4: return 32'(h);
            default: return md;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic mis, wr;
        if (!rst_n) begin
            m_valid = 0; m_rw = 0; m_adel = 0;
            m_addr = 0; m_data = 0; m_fpc = 0; m_cnt = 0;
        end else if (Flush_wb) begin
            m_valid = 0; m_rw = 0; m_adel = 0;
            m_addr = 0; m_data = 0; m_fpc = 0;
        end else if (!Stall_wb) begin
            mis = 0;
            if (Valid_mem && MemToReg_mem) begin
                if (LoadType_mem == 3 || LoadType_mem == 4)
                    mis = (ALUResult_mem % 2) != 0;
                else if (LoadType_mem != 1 && LoadType_mem != 2)
                    mis = (ALUResult_mem % 4) != 0;
            end
            wr = Valid_mem && RegWrite_mem &&
                 RegWriteAddr_mem != 0 && !mis;
            m_valid = Valid_mem;
            m_rw = wr;
            m_adel = mis;
            m_fpc = mis ? PC_plus4_mem - 4 : 0;
            m_addr = wr ? RegWriteAddr_mem : 0;
            if (!wr) m_data = 0;
            else if (Link_mem) m_data = PC_plus4_mem + 4;
            else if (MemToReg_mem)
                m_data = load_val(LoadType_mem, ALUResult_mem,
                                  MemData_mem);
            else m_data = ALUResult_mem;
            if (Valid_mem && !mis) m_cnt = m_cnt + 1;
        end
    end

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("valid", 32'(Valid_wb), 32'(m_valid));
            chk("rw", 32'(RegWrite_wb), 32'(m_rw));
            chk("addr", 32'(RegWriteAddr_wb), 32'(m_addr));
            chk("data", RegWriteData_wb, m_data);
            chk("adel", 32'(AdEL_wb), 32'(m_adel));
            chk("fpc", FaultPC_wb, m_fpc);
            chk("cnt", Retired_cnt, m_cnt);
            chk("cnt4", 32'(c4), m_cnt % 16);
            chk("d4", d4, m_data);
            chk("v4", {v4, rw4, ad4, a4, f4[23:0]},
                {m_valid, m_rw, m_adel, m_addr, m_fpc[23:0]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic setin(input logic v, input logic rw,
                         input logic [4:0] a, input logic m2r,
                         input logic lk, input logic [2:0] lt,
                         input logic [31:0] alu,
                         input logic [31:0] pc,
                         input logic [31:0] md);
        Valid_mem = v; RegWrite_mem = rw; RegWriteAddr_mem = a;
        MemToReg_mem = m2r; Link_mem = lk; LoadType_mem = lt;
        ALUResult_mem = alu; PC_plus4_mem = pc; MemData_mem = md;
    endtask

    task automatic ld(input logic [2:0] lt, input logic [1:0] k,
                      input logic [31:0] exp, input string n);
        setin(1, 1, 3, 1, 0, lt, 32'h1000 | 32'(k),
              32'h400004, 32'h81F2_7F80);
        cyc();
        chk(n, RegWriteData_wb, exp);
        chk({n, "_model"}, m_data, exp);
    endtask

    initial begin
        logic [31:0] c0;
        // reset with a valid LW to $5 on the inputs
        setin(1, 1, 5, 1, 0, 0, 32'h1000, 32'h400004, 32'hCAFE);
        #23;
        chk("rst_valid", 32'(Valid_wb), 0);
        chk("rst_rw", 32'(RegWrite_wb), 0);
        chk("rst_data", RegWriteData_wb, 0);
        chk("rst_cnt", Retired_cnt, 0);
        rst_n = 1;
        cyc();
        chk("first_rw", 32'(RegWrite_wb), 1);
        chk("first_addr", 32'(RegWriteAddr_wb), 5);
        chk("first_cnt", Retired_cnt, 1);

        ld(1, 1, 32'h0000_007F, "lb01");
        ld(1, 0, 32'hFFFF_FF80, "lb00");
        ld(2, 3, 32'h0000_0081, "lbu11");
        ld(3, 2, 32'hFFFF_81F2, "lh10");
        ld(4, 0, 32'h0000_7F80, "lhu00");
        ld(0, 0, 32'h81F2_7F80, "lw00");

        c0 = Retired_cnt;
        setin(1, 1, 3, 1, 0, 0, 32'h1002, 32'h0040_0010, 0);
        cyc();
        chk("lw_adel", 32'(AdEL_wb), 1);
        chk("lw_fpc", FaultPC_wb, 32'h0040_000C);
        chk("lw_rw", 32'(RegWrite_wb), 0);
        chk("lw_cnt", Retired_cnt, c0);
        setin(1, 1, 3, 1, 0, 3, 32'h1001, 32'h0040_0010, 0);
        cyc();
        chk("lh_adel", 32'(AdEL_wb), 1);
        chk("lh_fpc", FaultPC_wb, 32'h0040_000C);
        setin(1, 1, 3, 1, 0, 1, 32'h1001, 32'h0040_0010, 0);
        cyc();
        chk("lb_adel", 32'(AdEL_wb), 0);
        chk("lb_rw", 32'(RegWrite_wb), 1);

        setin(1, 1, 31, 0, 1, 0, 0, 32'h0040_0020, 0);
        cyc();
        chk("link", RegWriteData_wb, 32'h0040_0024);
        c0 = Retired_cnt;
        setin(1, 1, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0);
        cyc();
        chk("r0_rw", 32'(RegWrite_wb), 0);
        chk("r0_data", RegWriteData_wb, 0);
        chk("r0_cnt", Retired_cnt, c0 + 1);

        // stall freezes everything
        setin(1, 1, 7, 0, 0, 0, 32'h1234_5678, 0, 0);
        cyc();
        c0 = Retired_cnt;
        Stall_wb = 1;
        for (int i = 0; i < 3; i++) begin
            setin(1, 1, 5'(i + 9), 0, 0, 0, $urandom, 0, 0);
            cyc();
            chk("stall_data", RegWriteData_wb, 32'h1234_5678);
            chk("stall_addr", 32'(RegWriteAddr_wb), 7);
            chk("stall_cnt", Retired_cnt, c0);
        end
        Flush_wb = 1;
        cyc();
        chk("sf_valid", 32'(Valid_wb), 0);
        chk("sf_rw", 32'(RegWrite_wb), 0);
        Flush_wb = 0;

        // fault held under stall, then cleared by reset
        Stall_wb = 0;
        setin(1, 1, 3, 1, 0, 0, 32'h2001, 32'h0040_0100, 0);
        cyc();
        Stall_wb = 1;
        cyc();
        chk("stall_adel", 32'(AdEL_wb), 1);
        chk("stall_fpc", FaultPC_wb, 32'h0040_00FC);
        #1 rst_n = 0;
        #1;
        chk("rst_adel", 32'(AdEL_wb), 0);
        chk("rst_fpc", FaultPC_wb, 0);
        chk("rst_cnt2", Retired_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        Stall_wb = 0;

        // 16 retirements interleaved with bubbles wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            setin(1, 1, 4, 0, 0, 0, 32'(i), 0, 0);
            cyc();
            setin(0, 1, 4, 0, 0, 0, 32'(i), 0, 0);
            cyc();
        end
        chk("wrap4", 32'(c4), 0);
        chk("wrap32", Retired_cnt, 16);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            Stall_wb = ($urandom_range(0, 9) == 0);
            Flush_wb = ($urandom_range(0, 14) == 0);
            setin(1'($urandom_range(0, 4) != 0), 1'($urandom),
                  5'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0),
                  3'($urandom), $urandom, $urandom, $urandom);
            if (i == 2000) begin
                #1 rst_n = 0;
                #2 rst_n = 1;
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
